// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin two-port arbiter sharing one RISC-V DMI link.
// Port 0 is the JTAG DTM and port 1 is the secondary debug host.
// Only one transaction is outstanding at a time.
// NOP and reserved ops are answered locally without any DMI traffic.
// Optional feature: define DMI_ARB_TIMEOUT_EN to abort hung DMI transactions
// after TIMEOUT_CYCLES cycles spent in REQ+WAIT.
module dmi_arbiter #(
  parameter int unsigned DMI_ADDR_WIDTH = 7,
  parameter int unsigned DMI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_req_valid,
  output logic                      m0_req_ready,
  input  logic [DMI_ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DMI_DATA_WIDTH-1:0] m0_req_data,
  input  logic [1:0]                m0_req_op,
  output logic                      m0_rsp_valid,
  input  logic                      m0_rsp_ready,
  output logic [DMI_DATA_WIDTH-1:0] m0_rsp_data,
  output logic [1:0]                m0_rsp_resp,
  input  logic                      m1_req_valid,
  output logic                      m1_req_ready,
  input  logic [DMI_ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DMI_DATA_WIDTH-1:0] m1_req_data,
  input  logic [1:0]                m1_req_op,
  output logic                      m1_rsp_valid,
  input  logic                      m1_rsp_ready,
  output logic [DMI_DATA_WIDTH-1:0] m1_rsp_data,
  output logic [1:0]                m1_rsp_resp,
  output logic                      dmi_req_valid,
  input  logic                      dmi_req_ready,
  output logic [DMI_ADDR_WIDTH-1:0] dmi_req_addr,
  output logic [DMI_DATA_WIDTH-1:0] dmi_req_data,
  output logic [1:0]                dmi_req_op,
  input  logic                      dmi_rsp_valid,
  output logic                      dmi_rsp_ready,
  input  logic [DMI_DATA_WIDTH-1:0] dmi_rsp_data,
  input  logic [1:0]                dmi_rsp_resp
);

  localparam logic [1:0] OP_NOP       = 2'b00;
  localparam logic [1:0] OP_READ      = 2'b01;
  localparam logic [1:0] OP_WRITE     = 2'b10;
  localparam logic [1:0] RESP_SUCCESS = 2'b00;
  localparam logic [1:0] RESP_FAILED  = 2'b10;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_tmo_range_err
    $error("dmi_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  state_e                    state_q;
  logic                      last_q;
  logic                      owner_q;
  logic [DMI_ADDR_WIDTH-1:0] req_addr_q;
  logic [DMI_DATA_WIDTH-1:0] req_data_q;
  logic [1:0]                req_op_q;
  logic [DMI_DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]                rsp_resp_q;

  logic                      win_c;
  logic                      accept_c;
  logic                      owner_rsp_ready_c;
  logic [DMI_ADDR_WIDTH-1:0] sel_addr_c;
  logic [DMI_DATA_WIDTH-1:0] sel_data_c;
  logic [1:0]                sel_op_c;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit_c;
  assign tmo_hit_c = (tmo_cnt_q >= TMO_LAST);
`endif

  // Round-robin winner selection and same-cycle accept in IDLE
  always_comb begin
    win_c             = 1'b0;
    accept_c          = 1'b0;
    owner_rsp_ready_c = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      win_c = ~last_q;
    end else begin
      win_c = m1_req_valid;
    end
    accept_c          = rst_n && (state_q == ST_IDLE) && (m0_req_valid || m1_req_valid);
    sel_addr_c        = win_c ? m1_req_addr : m0_req_addr;
    sel_data_c        = win_c ? m1_req_data : m0_req_data;
    sel_op_c          = win_c ? m1_req_op   : m0_req_op;
    owner_rsp_ready_c = owner_q ? m1_rsp_ready : m0_rsp_ready;
  end

  assign m0_req_ready  = accept_c && !win_c;
  assign m1_req_ready  = accept_c && win_c;
  assign dmi_req_valid = (state_q == ST_REQ);
  assign dmi_rsp_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign dmi_req_addr  = req_addr_q;
  assign dmi_req_data  = req_data_q;
  assign dmi_req_op    = req_op_q;
  assign m0_rsp_valid  = (state_q == ST_RSP) && !owner_q;
  assign m1_rsp_valid  = (state_q == ST_RSP) && owner_q;
  assign m0_rsp_data   = rsp_data_q;
  assign m1_rsp_data   = rsp_data_q;
  assign m0_rsp_resp   = rsp_resp_q;
  assign m1_rsp_resp   = rsp_resp_q;

  // Transaction FSM: accept, forward to DM, collect response, return to owner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_op_q   <= OP_NOP;
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_SUCCESS;
`ifdef DMI_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            owner_q    <= win_c;
            last_q     <= win_c;
            req_addr_q <= sel_addr_c;
            req_data_q <= sel_data_c;
            req_op_q   <= sel_op_c;
            if ((sel_op_c == OP_READ) || (sel_op_c == OP_WRITE)) begin
              state_q   <= ST_REQ;
`ifdef DMI_ARB_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end else begin
              state_q    <= ST_RSP;
              rsp_data_q <= '0;
              rsp_resp_q <= (sel_op_c == OP_NOP) ? RESP_SUCCESS : RESP_FAILED;
            end
          end
        end
        ST_REQ: begin
          if (dmi_req_ready) begin
            state_q   <= ST_WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end else if (tmo_hit_c) begin
            state_q    <= ST_RSP;
            rsp_data_q <= '0;
            rsp_resp_q <= RESP_FAILED;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
          end
        end
        ST_WAIT: begin
          if (dmi_rsp_valid) begin
            state_q    <= ST_RSP;
            rsp_data_q <= dmi_rsp_data;
            rsp_resp_q <= dmi_rsp_resp;
`ifdef DMI_ARB_TIMEOUT_EN
          end else if (tmo_hit_c) begin
            state_q    <= ST_RSP;
            rsp_data_q <= '0;
            rsp_resp_q <= RESP_FAILED;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
          end
        end
        ST_RSP: begin
          if (owner_rsp_ready_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: transaction-level model plus directed tests.
module tb_dmi_arbiter;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk, rst_n;
  logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
  logic [6:0]  m0_req_addr;
  logic [31:0] m0_req_data, m0_rsp_data;
  logic [1:0]  m0_req_op, m0_rsp_resp;
  logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
  logic [6:0]  m1_req_addr;
  logic [31:0] m1_req_data, m1_rsp_data;
  logic [1:0]  m1_req_op, m1_rsp_resp;
  logic        dmi_req_valid, dmi_req_ready, dmi_rsp_valid, dmi_rsp_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data, dmi_rsp_data;
  logic [1:0]  dmi_req_op, dmi_rsp_resp;

  dmi_arbiter #(.DMI_ADDR_WIDTH(7), .DMI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_data(m0_req_data), .m0_req_op(m0_req_op), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_data(m0_rsp_data), .m0_rsp_resp(m0_rsp_resp),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_data(m1_req_data), .m1_req_op(m1_req_op), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_data(m1_rsp_data), .m1_rsp_resp(m1_rsp_resp),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr),
    .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op), .dmi_rsp_valid(dmi_rsp_valid),
    .dmi_rsp_ready(dmi_rsp_ready), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_resp(dmi_rsp_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Transaction model: phase 0 free, 1 DM request owed, 2 DM response owed, 3 port response owed
  int          ph_m = 0;
  logic        last_m = 1'b1, own_m = 1'b0;
  logic [6:0]  a_m;
  logic [31:0] d_m, rd_m;
  logic [1:0]  op_m, rr_m;
  int          tcnt_m;
  int          cyc = 0;
  int          t_acc, t_dreq, t_rsp;
  bit          dlog, rlog;
  logic [6:0]  dq_addr;
  logic [1:0]  dq_op;
  logic        cap_port;
  logic [31:0] cap_data;
  logic [1:0]  cap_resp;
  int          dreq_cnt = 0;
  bit          hs0 = 1'b0, hs1 = 1'b0;
  int          grant_log[$];
  int          done_log[$];

  task automatic model_step();
    logic w, any, rdy0, rdy1;
    cyc++;
    any  = m0_req_valid || m1_req_valid;
    w    = (m0_req_valid && m1_req_valid) ? (last_m == 1'b0) : m1_req_valid;
    rdy0 = (ph_m == 0) && any && !w;
    rdy1 = (ph_m == 0) && any && w;
    checkb("m0_req_ready", m0_req_ready, rdy0);
    checkb("m1_req_ready", m1_req_ready, rdy1);
    checkb("dmi_req_valid", dmi_req_valid, ph_m == 1);
    checkb("dmi_rsp_ready", dmi_rsp_ready, (ph_m == 0) || (ph_m == 2));
    checkb("m0_rsp_valid", m0_rsp_valid, (ph_m == 3) && !own_m);
    checkb("m1_rsp_valid", m1_rsp_valid, (ph_m == 3) && own_m);
    if (ph_m == 1) begin
      check("dmi_req_addr", 32'(dmi_req_addr), 32'(a_m));
      check("dmi_req_data", dmi_req_data, d_m);
      check("dmi_req_op", 32'(dmi_req_op), 32'(op_m));
      if (!dlog) begin
        dlog = 1'b1; t_dreq = cyc; dq_addr = dmi_req_addr; dq_op = dmi_req_op;
      end
    end
    if (ph_m == 3) begin
      check("rsp_data", own_m ? m1_rsp_data : m0_rsp_data, rd_m);
      check("rsp_resp", 32'(own_m ? m1_rsp_resp : m0_rsp_resp), 32'(rr_m));
      if (!rlog) begin
        rlog = 1'b1; t_rsp = cyc;
      end
    end
    if (dmi_req_valid) dreq_cnt++;
    hs0 = m0_req_valid && m0_req_ready;
    hs1 = m1_req_valid && m1_req_ready;
    case (ph_m)
      0: if (any) begin
        own_m  = w;
        last_m = w;
        a_m    = w ? m1_req_addr : m0_req_addr;
        d_m    = w ? m1_req_data : m0_req_data;
        op_m   = w ? m1_req_op   : m0_req_op;
        t_acc  = cyc; dlog = 1'b0; rlog = 1'b0;
        grant_log.push_back(m0_req_ready ? 0 : (m1_req_ready ? 1 : 2));
        if (op_m == 2'b01 || op_m == 2'b10) begin
          ph_m = 1; tcnt_m = 0;
        end else begin
          ph_m = 3; rd_m = 32'd0; rr_m = (op_m == 2'b00) ? 2'b00 : 2'b10;
        end
      end
      1: begin
        tcnt_m++;
        if (dmi_req_ready) ph_m = 2;
`ifdef DMI_ARB_TIMEOUT_EN
        else if (tcnt_m >= int'(TMO)) begin ph_m = 3; rd_m = 32'd0; rr_m = 2'b10; end
`endif
      end
      2: begin
        tcnt_m++;
        if (dmi_rsp_valid) begin ph_m = 3; rd_m = dmi_rsp_data; rr_m = dmi_rsp_resp; end
`ifdef DMI_ARB_TIMEOUT_EN
        else if (tcnt_m >= int'(TMO)) begin ph_m = 3; rd_m = 32'd0; rr_m = 2'b10; end
`endif
      end
      default: if (own_m ? m1_rsp_ready : m0_rsp_ready) begin
        cap_port = own_m;
        cap_data = own_m ? m1_rsp_data : m0_rsp_data;
        cap_resp = own_m ? m1_rsp_resp : m0_rsp_resp;
        done_log.push_back(int'(own_m));
        ph_m = 0;
      end
    endcase
  endtask

  // Per-cycle compare against the model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph_m = 0; last_m = 1'b1; own_m = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (ph_m != 0 && n < budget) begin
      tick();
      n++;
    end
    checkb("idle_wait_bound", ph_m == 0, 1'b1);
  endtask

  task automatic issue(input logic port, input logic [1:0] op, input logic [6:0] addr,
                       input logic [31:0] data);
    if (port) begin
      m1_req_valid = 1'b1; m1_req_op = op; m1_req_addr = addr; m1_req_data = data;
    end else begin
      m0_req_valid = 1'b1; m0_req_op = op; m0_req_addr = addr; m0_req_data = data;
    end
    tick();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  initial begin
    int g0, c0, k0, k1;
    rst_n = 1'b0;
    m0_req_valid = 0; m0_req_addr = '0; m0_req_data = '0; m0_req_op = '0; m0_rsp_ready = 1;
    m1_req_valid = 0; m1_req_addr = '0; m1_req_data = '0; m1_req_op = '0; m1_rsp_ready = 1;
    dmi_req_ready = 0; dmi_rsp_valid = 0; dmi_rsp_data = '0; dmi_rsp_resp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkb("rst dmi_rsp_ready", dmi_rsp_ready, 1'b1);
    checkb("rst dmi_req_valid", dmi_req_valid, 1'b0);
    checkb("rst m0_rsp_valid", m0_rsp_valid, 1'b0);
    checkb("rst m1_rsp_valid", m1_rsp_valid, 1'b0);
    checkb("rst m0_req_ready", m0_req_ready, 1'b0);
    checkb("rst m1_req_ready", m1_req_ready, 1'b0);
    check("rst dmi_req_addr", 32'(dmi_req_addr), 32'd0);
    check("rst dmi_req_data", dmi_req_data, 32'd0);
    check("rst dmi_req_op", 32'(dmi_req_op), 32'd0);
    check("rst m0_rsp_data", m0_rsp_data, 32'd0);
    check("rst m0_rsp_resp", 32'(m0_rsp_resp), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Contention: both ports write continuously, two transactions each
    g0 = grant_log.size(); c0 = done_log.size(); k0 = 0; k1 = 0;
    dmi_req_ready = 1; dmi_rsp_valid = 1; dmi_rsp_resp = 2'b00;
    m0_req_valid = 1; m0_req_op = 2'b10; m0_req_addr = 7'h20; m0_req_data = 32'h1000_0000;
    m1_req_valid = 1; m1_req_op = 2'b10; m1_req_addr = 7'h30; m1_req_data = 32'h2000_0000;
    for (int i = 0; i < 80 && !(k0 == 2 && k1 == 2 && ph_m == 0); i++) begin
      dmi_rsp_data = 32'hC0DE_0000 | 32'(i);
      tick();
      if (hs0) begin
        k0++;
        if (k0 == 2) m0_req_valid = 0; else begin m0_req_addr++; m0_req_data++; end
      end
      if (hs1) begin
        k1++;
        if (k1 == 2) m1_req_valid = 0; else begin m1_req_addr++; m1_req_data++; end
      end
    end
    check("contention grants", 32'(grant_log.size() - g0), 32'd4);
    check("contention completions", 32'(done_log.size() - c0), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (g0 + j < grant_log.size()) check("contention grant order", 32'(grant_log[g0 + j]), 32'(j % 2));
      if (c0 + j < done_log.size()) check("contention rsp routing", 32'(done_log[c0 + j]), 32'(j % 2));
    end

    // Single read with a zero-wait DM
    wait_idle(20);
    dmi_req_ready = 1; dmi_rsp_valid = 1; dmi_rsp_data = 32'hDEADBEEF; dmi_rsp_resp = 2'b00;
    issue(1'b0, 2'b01, 7'h11, 32'h0);
    wait_idle(20);
    check("read dmi addr", 32'(dq_addr), 32'h11);
    check("read dmi op", 32'(dq_op), 32'h1);
    check("read dmi latency", 32'(t_dreq - t_acc), 32'd1);
    check("read rsp latency", 32'(t_rsp - t_acc), 32'd3);
    checkb("read rsp port", cap_port, 1'b0);
    check("read rsp data", cap_data, 32'hDEADBEEF);
    check("read rsp resp", 32'(cap_resp), 32'd0);

    // Local ops on port 1: NOP then reserved
    dmi_req_ready = 0; dmi_rsp_valid = 0; dreq_cnt = 0;
    issue(1'b1, 2'b00, 7'h3F, 32'hFFFF_FFFF);
    wait_idle(20);
    check("nop rsp latency", 32'(t_rsp - t_acc), 32'd1);
    checkb("nop rsp port", cap_port, 1'b1);
    check("nop rsp data", cap_data, 32'd0);
    check("nop rsp resp", 32'(cap_resp), 32'd0);
    issue(1'b1, 2'b11, 7'h01, 32'h1234_5678);
    wait_idle(20);
    check("rsvd rsp resp", 32'(cap_resp), 32'h2);
    check("rsvd rsp data", cap_data, 32'd0);
    check("local dmi traffic", 32'(dreq_cnt), 32'd0);

    // Backpressure on both the DM and the requester, BUSY returned unchanged
    m0_rsp_ready = 0; dmi_req_ready = 0; dmi_rsp_valid = 0;
    issue(1'b0, 2'b10, 7'h05, 32'h1234_5678);
    repeat (5) tick();
    dmi_req_ready = 1;
    tick();
    dmi_req_ready = 0;
    repeat (2) tick();
    dmi_rsp_valid = 1; dmi_rsp_data = 32'hBAD0_BAD0; dmi_rsp_resp = 2'b11;
    tick();
    dmi_rsp_valid = 0;
    repeat (3) tick();
    m0_rsp_ready = 1;
    wait_idle(10);
    check("busy rsp resp", 32'(cap_resp), 32'h3);
    check("busy rsp data", cap_data, 32'hBAD0_BAD0);
    check("busy rsp latency", 32'(t_rsp - t_acc), 32'd10);

    // Reset in WAIT abandons the transaction and restores last=1
    dmi_req_ready = 1; dmi_rsp_valid = 0;
    issue(1'b0, 2'b01, 7'h22, 32'h0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkb("post-rst m0_rsp_valid", m0_rsp_valid, 1'b0);
    checkb("post-rst m1_rsp_valid", m1_rsp_valid, 1'b0);
    checkb("post-rst dmi_req_valid", dmi_req_valid, 1'b0);
    checkb("post-rst dmi_rsp_ready", dmi_rsp_ready, 1'b1);
    m0_req_valid = 1; m0_req_op = 2'b01; m0_req_addr = 7'h40; m0_req_data = 32'h0;
    m1_req_valid = 1; m1_req_op = 2'b01; m1_req_addr = 7'h41; m1_req_data = 32'h0;
    @(negedge clk); #1;
    checkb("post-rst m0 wins", m0_req_ready, 1'b1);
    checkb("post-rst m1 waits", m1_req_ready, 1'b0);
    dmi_rsp_valid = 1; dmi_rsp_data = 32'h0BAD_F00D; dmi_rsp_resp = 2'b00;
    tick();
    m0_req_valid = 0;
    for (int i = 0; i < 40 && m1_req_valid; i++) begin
      tick();
      if (hs1) m1_req_valid = 0;
    end
    checkb("post-rst m1 accepted", m1_req_valid, 1'b0);
    m1_req_valid = 0;
    wait_idle(20);
    checkb("post-rst last rsp port", cap_port, 1'b1);

`ifdef DMI_ARB_TIMEOUT_EN
    // Timeout: DM never answers, then a stray response in IDLE is dropped
    dmi_req_ready = 1; dmi_rsp_valid = 0;
    issue(1'b0, 2'b01, 7'h33, 32'h0);
    wait_idle(40);
    check("tmo rsp resp", 32'(cap_resp), 32'h2);
    check("tmo rsp data", cap_data, 32'd0);
    check("tmo rsp latency", 32'(t_rsp - t_acc), 32'(TMO + 1));
    dmi_rsp_valid = 1; dmi_rsp_data = 32'h5555_5555;
    tick();
    dmi_rsp_valid = 0;
    checkb("stray m0_rsp_valid", m0_rsp_valid, 1'b0);
    checkb("stray m1_rsp_valid", m1_rsp_valid, 1'b0);
    dmi_rsp_valid = 1; dmi_rsp_data = 32'h600D_600D; dmi_rsp_resp = 2'b00;
    issue(1'b1, 2'b01, 7'h34, 32'h0);
    wait_idle(20);
    checkb("post-tmo rsp port", cap_port, 1'b1);
    check("post-tmo rsp data", cap_data, 32'h600D_600D);
    check("post-tmo rsp resp", 32'(cap_resp), 32'd0);
`endif

    dmi_rsp_valid = 0; dmi_req_ready = 0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
